clk_activity_monitor: RTL

- Multi-channel successor to the single-bit clock-detect cell.
- Watches NCH monitored clock signals, already synchronised into CLK, over repeating fixed-length windows.
- Declares a channel PRESENT only after LOCK_WIN consecutive good windows; drops it on the first bad window and sets a sticky loss flag.
- Sits beside clock-generation/PLL logic as the system clock-health monitor.

---
 rtl/clk_activity_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clk_activity_monitor.sv
// Multi-channel clock activity monitor. Counts rising edges per channel over fixed windows and
// tracks presence through a small per-channel lock FSM with a sticky loss flag.
module clk_activity_monitor #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned WIN_W     = 8,
    parameter int unsigned MIN_EDGES = 2,
    parameter int unsigned LOCK_WIN  = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic [NCH-1:0] MON,
    input  logic [NCH-1:0] CLR_LOSS,
    output logic [NCH-1:0] PRESENT,
    output logic [NCH-1:0] LOSS,
    output logic           WIN_DONE
);

    localparam int unsigned EW  = $clog2(MIN_EDGES + 1);
    localparam int unsigned EW1 = EW + 1;
    localparam int unsigned GW  = $clog2(LOCK_WIN + 1);
    localparam int unsigned GW1 = GW + 1;

    localparam logic [1:0] ST_ABSENT  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             terminal;
    logic             win_done_q;
    logic [NCH-1:0]   mon_q, edge_det, good, loss_set;
    logic [NCH-1:0]   present_q, present_d, loss_q, loss_d;
    logic [EW-1:0]    ecnt_q [NCH];
    logic [EW-1:0]    ecnt_d [NCH];
    logic [EW:0]      ecnt_sum [NCH];
    logic [GW-1:0]    gcnt_q [NCH];
    logic [GW-1:0]    gcnt_d [NCH];
    logic [GW:0]      gcnt_inc [NCH];
    logic [1:0]       state_q [NCH];
    logic [1:0]       state_d [NCH];

    assign terminal = EN && (win_cnt_q == WIN_W'(WINDOW - 1));
    assign edge_det = MON & ~mon_q;

    always_comb begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (!EN || terminal) begin
            win_cnt_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            // A rising edge in the terminal cycle still counts toward the ending window.
            ecnt_sum[i] = {1'b0, ecnt_q[i]} + EW1'(edge_det[i]);
            good[i]     = ecnt_sum[i] >= EW1'(MIN_EDGES);

            if (!EN || terminal) begin
                ecnt_d[i] = '0;
            end else if (edge_det[i] && (ecnt_q[i] < EW'(MIN_EDGES))) begin
                ecnt_d[i] = ecnt_q[i] + EW'(1);
            end else begin
                ecnt_d[i] = ecnt_q[i];
            end

            gcnt_inc[i] = {1'b0, gcnt_q[i]} + GW1'(1);
            state_d[i]  = state_q[i];
            gcnt_d[i]   = gcnt_q[i];
            loss_set[i] = 1'b0;

            if (terminal) begin
                case (state_q[i])
                    ST_ABSENT: begin
                        if (good[i]) begin
                            if (LOCK_WIN == 1) begin
                                state_d[i] = ST_PRESENT;
                            end else begin
                                state_d[i] = ST_ACQUIRE;
                                gcnt_d[i]  = GW'(1);
                            end
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!good[i]) begin
                            state_d[i] = ST_ABSENT;
                            gcnt_d[i]  = '0;
                        end else if (gcnt_inc[i] >= GW1'(LOCK_WIN)) begin
                            state_d[i] = ST_PRESENT;
                            gcnt_d[i]  = '0;
                        end else begin
                            gcnt_d[i] = gcnt_inc[i][GW-1:0];
                        end
                    end
                    ST_PRESENT: begin
                        if (!good[i]) begin
                            state_d[i]  = ST_ABSENT;
                            gcnt_d[i]   = '0;
                            loss_set[i] = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_ABSENT;
                        gcnt_d[i]  = '0;
                    end
                endcase
            end

            present_d[i] = (state_d[i] == ST_PRESENT);
            // Set has priority over a coincident clear.
            loss_d[i]    = loss_set[i] | (loss_q[i] & ~CLR_LOSS[i]);
        end
    end

    always_ff @(posedge CLK) begin
        mon_q <= MON;
        if (RST) begin
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
            present_q  <= '0;
            loss_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                ecnt_q[i]  <= '0;
                gcnt_q[i]  <= '0;
                state_q[i] <= ST_ABSENT;
            end
        end else begin
            win_cnt_q  <= win_cnt_d;
            win_done_q <= terminal;
            present_q  <= present_d;
            loss_q     <= loss_d;
            for (int i = 0; i < NCH; i++) begin
                ecnt_q[i]  <= ecnt_d[i];
                gcnt_q[i]  <= gcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign PRESENT  = present_q;
    assign LOSS     = loss_q;
    assign WIN_DONE = win_done_q;

endmodule
